// File: rtl/bus_host_arbiter.sv
// Generic synchronous FIFO with an exposed occupancy count and head peek.
// Latency: a pushed entry is visible at head_dat the cycle after the push.
// Backpressure: none internally; the user must not push when full nor pop when empty.
module fifo #(
    parameter int Width = 1,
    parameter int Depth = 2,
    parameter int CntW  = $clog2(Depth + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_vld,
    input  logic [Width-1:0] push_dat,
    input  logic             pop_vld,
    output logic [Width-1:0] head_dat,
    output logic [CntW-1:0]  count
);

    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wr_ptr;
    logic [PtrW-1:0]  rd_ptr;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    // Storage array; contents are only meaningful while count is non-zero.
    always_ff @(posedge clk_i) begin
        if (push_vld) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointer and occupancy bookkeeping; push+pop together leaves count unchanged.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_vld) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop_vld) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push_vld, pop_vld})
                2'b10:   count <= count + CntW'(1);
                2'b01:   count <= count - CntW'(1);
                default: count <= count;
            endcase
        end
    end

    assign head_dat = mem[rd_ptr];

endmodule

// Round-robin arbiter merging several Ibex-protocol hosts onto one bus host port.
// Latency: zero-cycle combinational request/grant and response paths; state moves on clk_i.
// Backpressure: a presented-but-ungranted request is locked until granted; no request while the ID FIFO is full.
module bus_host_arbiter #(
    parameter int NrHosts        = 2,
    parameter int DataWidth      = 32,
    parameter int AddressWidth   = 32,
    parameter int MaxOutstanding = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,

    input  logic                    host_req_i    [NrHosts],
    output logic                    host_gnt_o    [NrHosts],
    input  logic [AddressWidth-1:0] host_addr_i   [NrHosts],
    input  logic                    host_we_i     [NrHosts],
    input  logic [3:0]              host_be_i     [NrHosts],
    input  logic [DataWidth-1:0]    host_wdata_i  [NrHosts],
    output logic                    host_rvalid_o [NrHosts],
    output logic [DataWidth-1:0]    host_rdata_o  [NrHosts],
    output logic                    host_err_o    [NrHosts],

    output logic                    out_req_o,
    input  logic                    out_gnt_i,
    output logic [AddressWidth-1:0] out_addr_o,
    output logic                    out_we_o,
    output logic [3:0]              out_be_o,
    output logic [DataWidth-1:0]    out_wdata_o,
    input  logic                    out_rvalid_i,
    input  logic [DataWidth-1:0]    out_rdata_i,
    input  logic                    out_err_i,

    output logic                    protocol_err_o
);

    localparam int IdW  = $clog2(NrHosts);
    localparam int CntW = $clog2(MaxOutstanding + 1);

    logic [IdW-1:0]  rr_ptr;
    logic            lock_vld;
    logic [IdW-1:0]  lock_id;
    logic [IdW-1:0]  scan_sel;
    logic [IdW-1:0]  sel;
    logic            sel_req;
    logic            grant;
    logic [IdW-1:0]  head_id;
    logic [CntW-1:0] count;
    logic            fifo_full;
    logic            fifo_empty;
    logic            rsp_vld;

    assign fifo_full  = (count == CntW'(MaxOutstanding));
    assign fifo_empty = (count == '0);

    // Round-robin scan from rr_ptr; walking the offsets downward lets the nearest requester win.
    always_comb begin
        int idx;
        scan_sel = rr_ptr;
        idx      = 0;
        for (int k = NrHosts - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NrHosts) begin
                idx = idx - NrHosts;
            end
            if (host_req_i[idx]) begin
                scan_sel = IdW'(idx);
            end
        end
    end

    // A locked request keeps the port so its payload cannot change under the bus.
    assign sel       = lock_vld ? lock_id : scan_sel;
    assign sel_req   = host_req_i[sel];
    // The full check uses the registered count, so a same-cycle pop does not reopen the port.
    assign out_req_o = sel_req & ~fifo_full;
    assign grant     = out_req_o & out_gnt_i;
    assign rsp_vld   = out_rvalid_i & ~fifo_empty;

    // Downstream payload mux; idle bus shows zeros.
    always_comb begin
        out_addr_o  = '0;
        out_we_o    = 1'b0;
        out_be_o    = '0;
        out_wdata_o = '0;
        if (sel_req) begin
            out_addr_o  = host_addr_i[sel];
            out_we_o    = host_we_i[sel];
            out_be_o    = host_be_i[sel];
            out_wdata_o = host_wdata_i[sel];
        end
    end

    // Per-host grant and response steering; read data is broadcast, valid/err go to the FIFO head.
    always_comb begin
        for (int i = 0; i < NrHosts; i++) begin
            host_gnt_o[i]    = grant && (sel == IdW'(i));
            host_rvalid_o[i] = rsp_vld && (head_id == IdW'(i));
            host_err_o[i]    = rsp_vld && out_err_i && (head_id == IdW'(i));
            host_rdata_o[i]  = out_rdata_i;
        end
    end

    // In-order record of which host owns each outstanding transaction.
    fifo #(
        .Width (IdW),
        .Depth (MaxOutstanding),
        .CntW  (CntW)
    ) u_id_fifo (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .push_vld (grant),
        .push_dat (sel),
        .pop_vld  (rsp_vld),
        .head_dat (head_id),
        .count    (count)
    );

    // Arbitration pointer, request lock and sticky spurious-response flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr         <= '0;
            lock_vld       <= 1'b0;
            lock_id        <= '0;
            protocol_err_o <= 1'b0;
        end else begin
            if (grant) begin
                rr_ptr   <= (sel == IdW'(NrHosts - 1)) ? '0 : sel + IdW'(1);
                lock_vld <= 1'b0;
            end else if (out_req_o) begin
                lock_vld <= 1'b1;
                lock_id  <= sel;
            end
            if (out_rvalid_i && fifo_empty) begin
                protocol_err_o <= 1'b1;
            end
        end
    end

endmodule

// File: doc/bus_host_arbiter.md
# bus_host_arbiter

Round-robin arbiter that lets several bus hosts (core data port, DMA engine, debug master) share the single host port of `bus`. Downstream it behaves as one Ibex-protocol host. It tracks outstanding transactions in an in-order ID FIFO so that each `rvalid`/`rdata`/`err` response returns to the host that issued the request. It sits between the hosts and `u_bus`, which then runs with `NrHosts = 1`.

## Interface
**Parameters**
- `NrHosts`, default 2: number of upstream hosts; must be ≥ 2.
- `DataWidth`, default 32: data width in bits.
- `AddressWidth`, default 32: address width in bits.
- `MaxOutstanding`, default 2: depth of the ID FIFO, i.e. maximum granted-but-unanswered transactions; must be ≥ 1.

**Ports** (host arrays are unpacked `[NrHosts]`)
- `clk_i` in 1: system clock.
- `rst_i` in 1: reset. **One clock; reset is asynchronous and active-high.**
- `host_req_i` in 1 per host: request.
- `host_gnt_o` out 1 per host: grant.
- `host_addr_i` in AddressWidth per host: address.
- `host_we_i` in 1 per host: write enable.
- `host_be_i` in 4 per host: byte enables.
- `host_wdata_i` in DataWidth per host: write data.
- `host_rvalid_o` out 1 per host: response valid.
- `host_rdata_o` out DataWidth per host: read data.
- `host_err_o` out 1 per host: response error.
- `out_req_o` out 1: request to bus.
- `out_gnt_i` in 1: bus grant.
- `out_addr_o` out AddressWidth: address to bus.
- `out_we_o` out 1: write enable to bus.
- `out_be_o` out 4: byte enables to bus.
- `out_wdata_o` out DataWidth: write data to bus.
- `out_rvalid_i` in 1: bus response valid.
- `out_rdata_i` in DataWidth: bus read data.
- `out_err_i` in 1: bus response error.
- `protocol_err_o` out 1: sticky flag; set by a response arriving with no transaction outstanding.

## Operation
**State**
- `rr_ptr`: `$clog2(NrHosts)` bits, the highest-priority host.
- `lock_vld` and `lock_id`: a request that has been presented but not yet granted.
- ID FIFO: `MaxOutstanding` entries of host IDs, with `count` of `$clog2(MaxOutstanding+1)` bits.
- `protocol_err_o` register.

**Selection (combinational)**
- When `lock_vld` = 1: `sel = lock_id`.
- Otherwise: `sel` is the first host with `host_req_i` = 1, scanning `rr_ptr`, `rr_ptr+1`, … modulo `NrHosts`.
- `out_req_o = host_req_i[sel] & (count != MaxOutstanding)`.
- `out_addr_o`, `out_we_o`, `out_be_o` and `out_wdata_o` mux from `sel`. They are 0 when no host requests.

**Grant**
- `host_gnt_o[sel] = out_req_o & out_gnt_i`; all other grants are 0.

**On grant (clock edge)**
- Push `sel` into the FIFO.
- `rr_ptr <= (sel == NrHosts-1) ? 0 : sel+1`.
- Clear `lock_vld`.

**Lock**
- If `out_req_o & ~out_gnt_i`: `lock_vld <= 1`, `lock_id <= sel`.
- The locked host keeps `out_*` until granted. New, higher-priority requests cannot preempt it.
- Hosts hold `req` and payload stable until `gnt`. This is the Ibex protocol and is not checked.

**FIFO full**
- When `count == MaxOutstanding`, `out_req_o` = 0, even if a pop occurs in the same cycle. This is a registered-count decision and is deliberate.
- `lock_vld` is kept through a full stall.

**Response**
- `host_rdata_o[i] = out_rdata_i` for all i (broadcast).
- If `count != 0`: `host_rvalid_o[head] = out_rvalid_i` and `host_err_o[head] = out_rvalid_i & out_err_i`; the FIFO pops on `out_rvalid_i`.
- Push and pop in the same cycle: `count` is unchanged and ordering is preserved.

**Spurious response**
- `out_rvalid_i` while `count == 0`: no `host_rvalid_o` is raised and `protocol_err_o <= 1`.
- `protocol_err_o` stays set until reset.

**Reset** (`rst_i` = 1, asynchronous, including mid-transaction)
- `rr_ptr = 0`, `lock_vld = 0`, `count = 0`, FIFO pointers = 0, `protocol_err_o = 0`.
- In-flight responses are discarded: a later `rvalid` counts as spurious.

## Timing
- Request path is zero-latency combinational: host `req` → `out_req_o`, `out_gnt_i` → `host_gnt_o`.
- Response path is zero-latency combinational: `out_rvalid_i` → `host_rvalid_o`.
- State updates on the `clk_i` rising edge. The arbitration pointer takes effect in the cycle after the grant.
- Back-to-back grants are possible every cycle until the FIFO fills. Sustained throughput with `MaxOutstanding` = 2 and one-cycle response is 1 transaction per cycle.
- Output values during reset:
  - `host_gnt_o`, `host_rvalid_o`, `host_err_o`: 0.
  - `out_req_o`: 0 while `count` is held at 0 and no host requests. It is still combinationally driven by `host_req_i`; the bench holds host requests low during reset.
  - `protocol_err_o`: 0.

## Test plan
- **Single read:** host0 req, addr 0x00100000, `out_gnt_i` = 1 in the same cycle → `host_gnt_o[0]` = 1 that cycle, `out_addr_o` = 0x00100000. Next cycle `out_rvalid_i` = 1 with rdata 0xDEADBEEF → `host_rvalid_o[0]` = 1, `host_rdata_o[0]` = 0xDEADBEEF, `host_rvalid_o[1]` = 0.
- **Fairness:** both hosts hold req, `out_gnt_i` = 1 every cycle, rvalid one cycle after each grant → grants go 0,1,0,1,… starting with host0 after reset. No host waits more than 1 extra grant.
- **Lock:**
  - Stimulus: host1 requests addr 0x30000 with `out_gnt_i` = 0 for 3 cycles; host0 raises req in cycle 1.
  - Required: `out_addr_o` = 0x30000 throughout, host1 is granted in cycle 3, host0 is granted in cycle 4.
- **Full stall:**
  - Stimulus: `MaxOutstanding` = 2, two grants with no rvalid.
  - Required: `out_req_o` = 0 while `count` = 2.
  - Follow-up: rvalid pops one entry → `out_req_o` = 1 the next cycle. Push and pop in the same cycle keep `count` = 1.
- **Ordering and error:** grant host0 then host1; rvalids arrive on consecutive cycles, the second with `out_err_i` = 1 → `host_rvalid_o[0]`, then `host_rvalid_o[1]` together with `host_err_o[1]` = 1.
- **Spurious response and reset:** `out_rvalid_i` with `count` = 0 → no `host_rvalid_o`, `protocol_err_o` = 1 and sticky. Assert `rst_i` with 1 transaction outstanding → `count` = 0 and `protocol_err_o` = 0 immediately; after reset, host0 has priority.
